ctrl_seq: RTL and testbench

//  8-phase instruction sequencer for the 8-bit RISC processor.

---
 rtl/ctrl_seq.sv | 136 +++++++++++++
 tb/tb_ctrl_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// 8-phase instruction sequencer for the 8-bit RISC processor.
// Decodes the phase counter, halt flag and current opcode into datapath strobes.
module ctrl_seq #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcd,
    input  logic       zr,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   is_hlt, is_skz, is_sto, is_jmp, aluop;

    // Opcodes outside the table (including X) fall to default and act as a no-op.
    always_comb begin
        is_hlt = 1'b0;
        is_skz = 1'b0;
        is_sto = 1'b0;
        is_jmp = 1'b0;
        aluop  = 1'b0;
        case (opcd)
            OP_HLT:                         is_hlt = 1'b1;
            OP_SKZ:                         is_skz = 1'b1;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: aluop  = 1'b1;
            OP_STO:                         is_sto = 1'b1;
            OP_JMP:                         is_jmp = 1'b1;
            default:                        ;
        endcase
    end

    always_comb begin
        phase_d  = phase_e'(phase_q + 3'd1);
        halted_d = halted_q;
        if (halted_q) begin
            phase_d = phase_q;
        end else if (HALT_STICKY && phase_q == OP_ADDR && is_hlt) begin
            phase_d  = phase_q;
            halted_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = is_skz & zr;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    // The held phase is OP_ADDR, so HALTED reads back as phase 4 without extra logic.
    assign phase = phase_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: directed per-feature tasks plus randomized traffic,
// all checked against a phase/halt model derived from the strobe table.
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcd = 3'd0;
    logic       zr = 1'b0;

    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;
    logic       sel_n, rd_n, ld_ir_n, halt_n, inc_pc_n, ld_ac_n, ld_pc_n, wr_n, data_e_n;
    logic [2:0] phase_n;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: phase and halted flag for the sticky DUT, phase for the pulse-halt DUT.
    int m_ph = 0;
    bit m_halt = 1'b0;
    int n_ph = 0;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;
    localparam logic [11:0] RESET_VEC  = 12'b1000_0000_0000;
    localparam logic [11:0] HALTED_VEC = 12'b0001_0000_0100;

    ctrl_seq #(.HALT_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .opcd(opcd), .zr(zr),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
        .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e), .phase(phase)
    );

    ctrl_seq #(.HALT_STICKY(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .opcd(opcd), .zr(zr),
        .sel(sel_n), .rd(rd_n), .ld_ir(ld_ir_n), .halt(halt_n), .inc_pc(inc_pc_n),
        .ld_ac(ld_ac_n), .ld_pc(ld_pc_n), .wr(wr_n), .data_e(data_e_n), .phase(phase_n)
    );

    logic [11:0] obs_s, obs_n;
    assign obs_s = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase};
    assign obs_n = {sel_n, rd_n, ld_ir_n, halt_n, inc_pc_n, ld_ac_n, ld_pc_n, wr_n, data_e_n, phase_n};

    always #5 clk = ~clk;

    // Expected strobes from the phase table, in obs_* bit order.
    function automatic logic [11:0] exp_vec(input int ph, input bit hl, input logic [2:0] op,
                                            input logic z);
        int o;
        bit alu, s, r, li, h, ip, la, lp, w, de;
        if (hl) return HALTED_VEC;
        o   = int'(op);
        alu = (o >= 2 && o <= 5);
        s   = (ph < 4);
        r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        li  = (ph == 2 || ph == 3);
        h   = (ph == 4 && o == 0);
        ip  = (ph == 4) || (ph == 6 && o == 1 && z);
        la  = (ph == 7 && alu);
        lp  = (ph >= 6 && o == 7);
        w   = (ph == 7 && o == 6);
        de  = (ph >= 6 && o == 6);
        return {s, r, li, h, ip, la, lp, w, de, 3'(ph)};
    endfunction

    task automatic apply(input logic r, input logic [2:0] op, input logic z);
        rst  = r;
        opcd = op;
        zr   = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_ph = 0;
            m_halt = 1'b0;
            n_ph = 0;
        end else begin
            if (!m_halt) begin
                if (m_ph == 4 && opcd == HLT) m_halt = 1'b1;
                else m_ph = (m_ph + 1) % 8;
            end
            n_ph = (n_ph + 1) % 8;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1'b1, ADD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (obs_s !== RESET_VEC) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs_s, RESET_VEC);
            end
        end
        for (int p = 0; p <= 8; p++) begin
            apply(1'b0, ADD, 1'b0);
            tests_run++;
            if (phase !== 3'(p % 8) || obs_s !== exp_vec(m_ph, m_halt, opcd, zr)) begin
                tests_failed++;
                $display("FAIL reset_seq[%0d]: got %b expected %b", p, obs_s,
                         exp_vec(p % 8, 1'b0, opcd, zr));
            end
            if (p < 8) tick();
        end
    endtask

    task automatic test_add();
        for (int p = 0; p < 8; p++) begin
            apply(1'b0, ADD, 1'($urandom_range(0, 1)));
            tests_run++;
            if (rd !== (p != 0 && p != 4) || ld_ac !== (p == 7) || wr !== 1'b0 ||
                data_e !== 1'b0 || ld_pc !== 1'b0 || obs_s !== exp_vec(m_ph, m_halt, opcd, zr)) begin
                tests_failed++;
                $display("FAIL add[%0d]: got %b expected %b", p, obs_s, exp_vec(m_ph, m_halt, opcd, zr));
            end
            tick();
        end
    endtask

    task automatic test_sto();
        for (int p = 0; p < 8; p++) begin
            apply(1'b0, STO, 1'($urandom_range(0, 1)));
            tests_run++;
            if (data_e !== (p >= 6) || wr !== (p == 7) || rd !== (p >= 1 && p <= 3) ||
                ld_ac !== 1'b0 || obs_s !== exp_vec(m_ph, m_halt, opcd, zr)) begin
                tests_failed++;
                $display("FAIL sto[%0d]: got %b expected %b", p, obs_s, exp_vec(m_ph, m_halt, opcd, zr));
            end
            tick();
        end
    endtask

    task automatic test_skz();
        for (int k = 0; k < 2; k++) begin
            int pulses = 0;
            logic z = (k == 0);
            for (int p = 0; p < 8; p++) begin
                apply(1'b0, SKZ, z);
                if (inc_pc === 1'b1) pulses++;
                tests_run++;
                if (obs_s !== exp_vec(m_ph, m_halt, opcd, zr)) begin
                    tests_failed++;
                    $display("FAIL skz_z%0b[%0d]: got %b expected %b", z, p, obs_s,
                             exp_vec(m_ph, m_halt, opcd, zr));
                end
                tick();
            end
            tests_run++;
            if (pulses != (z ? 2 : 1)) begin
                tests_failed++;
                $display("FAIL skz_pulses_z%0b: got %0d expected %0d", z, pulses, z ? 2 : 1);
            end
        end
    endtask

    task automatic test_jmp();
        for (int p = 0; p < 8; p++) begin
            apply(1'b0, JMP, 1'($urandom_range(0, 1)));
            tests_run++;
            if (ld_pc !== (p >= 6) || inc_pc !== (p == 4) ||
                obs_s !== exp_vec(m_ph, m_halt, opcd, zr)) begin
                tests_failed++;
                $display("FAIL jmp[%0d]: got %b expected %b", p, obs_s, exp_vec(m_ph, m_halt, opcd, zr));
            end
            tick();
        end
    endtask

    task automatic test_halt();
        for (int p = 0; p < 5; p++) begin
            apply(1'b0, HLT, 1'b0);
            tests_run++;
            if (obs_s !== exp_vec(m_ph, m_halt, opcd, zr) || halt !== (p == 4)) begin
                tests_failed++;
                $display("FAIL hlt_fetch[%0d]: got %b expected %b", p, obs_s,
                         exp_vec(m_ph, m_halt, opcd, zr));
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, HLT, 1'($urandom_range(0, 1)));
            tests_run++;
            if (obs_s !== HALTED_VEC) begin
                tests_failed++;
                $display("FAIL halted[%0d]: got %b expected %b", i, obs_s, HALTED_VEC);
            end
            tests_run++;
            if (obs_n !== exp_vec(n_ph, 1'b0, opcd, zr)) begin
                tests_failed++;
                $display("FAIL hlt_pulse[%0d]: got %b expected %b", i, obs_n,
                         exp_vec(n_ph, 1'b0, opcd, zr));
            end
            tick();
        end
        apply(1'b1, HLT, 1'b0);
        tick();
        apply(1'b0, HLT, 1'b0);
        tests_run++;
        if (obs_s !== RESET_VEC || obs_n !== RESET_VEC) begin
            tests_failed++;
            $display("FAIL hlt_release: got %b / %b expected %b", obs_s, obs_n, RESET_VEC);
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 6; p++) begin
            apply(1'b0, ADD, 1'b0);
            tests_run++;
            if (obs_s !== exp_vec(m_ph, m_halt, opcd, zr)) begin
                tests_failed++;
                $display("FAIL rst_mid_pre[%0d]: got %b expected %b", p, obs_s,
                         exp_vec(m_ph, m_halt, opcd, zr));
            end
            tick();
        end
        apply(1'b1, ADD, 1'b0);
        tick();
        apply(1'b0, ADD, 1'b0);
        tests_run++;
        if (phase !== 3'd0 || ld_ac !== 1'b0 || obs_s !== RESET_VEC) begin
            tests_failed++;
            $display("FAIL rst_mid: got %b expected %b", obs_s, RESET_VEC);
        end
    endtask

    task automatic test_random();
        logic [2:0] rop = ADD;
        for (int i = 0; i < 600; i++) begin
            if (n_ph == 0) rop = 3'($urandom);
            apply(1'($urandom_range(0, 24) == 0), rop, 1'($urandom_range(0, 1)));
            tests_run++;
            if (obs_s !== exp_vec(m_ph, m_halt, opcd, zr)) begin
                tests_failed++;
                $display("FAIL rand_sticky[%0d]: got %b expected %b", i, obs_s,
                         exp_vec(m_ph, m_halt, opcd, zr));
            end
            tests_run++;
            if (obs_n !== exp_vec(n_ph, 1'b0, opcd, zr)) begin
                tests_failed++;
                $display("FAIL rand_pulse[%0d]: got %b expected %b", i, obs_n,
                         exp_vec(n_ph, 1'b0, opcd, zr));
            end
            tests_run++;
            if ((wr && !data_e) || (ld_ir && ld_ac) || (wr_n && !data_e_n) || (ld_ir_n && ld_ac_n)) begin
                tests_failed++;
                $display("FAIL rand_ordering[%0d]: got %b / %b expected wr->data_e, !(ld_ir&ld_ac)",
                         i, obs_s, obs_n);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sto();
        test_skz();
        test_jmp();
        test_halt();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
